// File: rtl/fp8_pkg.sv
// Shared FP8 definitions: {sign, exp (bias 3), man with hidden 1}, field slices and divider FSM states.
package fp8_pkg;
    localparam int EXP_W    = 3;
    localparam int MAN_W    = 4;
    localparam int BIAS     = 3;

    localparam int SIGN_BIT = EXP_W + MAN_W;
    localparam int EXP_MSB  = EXP_W + MAN_W - 1;
    localparam int EXP_LSB  = MAN_W;
    localparam int MAN_MSB  = MAN_W - 1;
    localparam int MAN_LSB  = 0;

    localparam int Q_W      = MAN_W + 2;
    localparam int E_W      = EXP_W + 2;
    localparam int MAX_EXP  = (1 << EXP_W) - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } div_state_t;
endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring mantissa divider: one quotient bit per clock, MSB first, Q_W bits total.
module fp_div_mant_iter
    import fp8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [MAN_W-1:0] a_man,
    input  logic [MAN_W-1:0] b_man,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   q
);
    logic [Q_W-1:0] r;
    logic [Q_W-1:0] d;
    logic [2:0]     cnt;
    logic           q_bit;
    logic [Q_W-1:0] r_sub;

    // R stays below 2*D after each step, so the shifted remainder fits in Q_W bits
    always_comb begin
        q_bit = (r >= d);
        r_sub = q_bit ? (r - d) : r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r    <= '0;
            d    <= '0;
            q    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r    <= {2'b01, a_man};
                d    <= {2'b01, b_man};
                q    <= '0;
                cnt  <= 3'(Q_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                r   <= r_sub << 1;
                q   <= {q[Q_W-2:0], q_bit};
                cnt <= cnt - 3'd1;
                if (cnt == 3'd0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/floating_pnt_div.sv
// Sequential FP8 divider out = a / b with valid/ready handshakes; truncating, saturating.
// Optional ovf/unf outputs when FP_DIV_FLAGS_EN is defined.
//
// state  | meaning
// IDLE   | waiting for in_valid, in_ready high
// DIV    | mantissa iterator running
// NORM   | normalise, saturate/flush, register result
// DONE   | result held until out_ready
module floating_pnt_div
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef FP_DIV_FLAGS_EN
    output logic       ovf,
    output logic       unf,
`endif
    output logic [7:0] out
);
    div_state_t            state;
    logic                  sign_r;
    logic signed [E_W-1:0] e_r;
    logic                  accept;
    logic                  it_busy;
    logic                  it_done;
    logic [Q_W-1:0]        q;
    logic signed [E_W-1:0] exp_n;
    logic [MAN_W-1:0]      man_n;
    logic                  ovf_n;
    logic                  unf_n;
    logic [7:0]            res;

    assign accept = in_valid && in_ready;

    fp_div_mant_iter u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .a_man (a[MAN_MSB:MAN_LSB]),
        .b_man (b[MAN_MSB:MAN_LSB]),
        .busy  (it_busy),
        .done  (it_done),
        .q     (q)
    );

    // Q in 16..63: top bit set means the quotient mantissa is already >= 1.0
    always_comb begin
        exp_n = q[Q_W-1] ? e_r : (e_r - E_W'(1));
        man_n = q[Q_W-1] ? q[MAN_W:1] : q[MAN_W-1:0];
        unf_n = (exp_n < 0);
        ovf_n = (exp_n > E_W'(MAX_EXP));
        if (unf_n)
            res = {sign_r, 7'h00};
        else if (ovf_n)
            res = {sign_r, 7'h7F};
        else
            res = {sign_r, exp_n[EXP_W-1:0], man_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sign_r    <= 1'b0;
            e_r       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= 8'h00;
`ifdef FP_DIV_FLAGS_EN
            ovf       <= 1'b0;
            unf       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_r   <= a[SIGN_BIT] ^ b[SIGN_BIT];
                        e_r      <= E_W'(a[EXP_MSB:EXP_LSB]) - E_W'(b[EXP_MSB:EXP_LSB]) + E_W'(BIAS);
                        in_ready <= 1'b0;
                        state    <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (it_done && !it_busy)
                        state <= S_NORM;
                end
                S_NORM: begin
                    out       <= res;
                    out_valid <= 1'b1;
`ifdef FP_DIV_FLAGS_EN
                    ovf       <= ovf_n;
                    unf       <= unf_n;
`endif
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
                        ovf       <= 1'b0;
                        unf       <= 1'b0;
`endif
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_floating_pnt_div.sv
// Bench for floating_pnt_div: directed and random divisions against a value-level FP8 model.
module tb_floating_pnt_div;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
`ifdef FP_DIV_FLAGS_EN
    logic       ovf;
    logic       unf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    floating_pnt_div dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FP_DIV_FLAGS_EN
        .ovf       (ovf),
        .unf       (unf),
`endif
        .out       (out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value-level reference: quotient mantissa truncated to 4 fraction bits after normalising to [1,2)
    function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output bit o, output bit u);
        int ea = int'(x[6:4]);
        int eb = int'(y[6:4]);
        int va = 16 + int'(x[3:0]);
        int vb = 16 + int'(y[3:0]);
        int e;
        int m;
        logic s;
        s = x[7] ^ y[7];
        if (va >= vb) begin
            m = (va * 16) / vb;
            e = ea - eb + 3;
        end else begin
            m = (va * 32) / vb;
            e = ea - eb + 2;
        end
        o = (e > 7);
        u = (e < 0);
        if (u)
            r = {s, 7'h00};
        else if (o)
            r = {s, 7'h7F};
        else
            r = {s, 3'(e), 4'(m - 16)};
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input int hold);
        logic [7:0] er;
        bit         eo;
        bit         eu;
        int         lat;
        model(ta, tb_v, er, eo, eu);
        @(negedge clk);
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd8);
        check($sformatf("out_%02h_%02h", ta, tb_v), 32'(out), 32'(er));
`ifdef FP_DIV_FLAGS_EN
        check("ovf", 32'(ovf), 32'(eo));
        check("unf", 32'(unf), 32'(eu));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid = 1'b1;
                a = 8'h30;
                b = 8'h30;
            end
            check("hold_out", 32'(out), 32'(er));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("ack_valid", 32'(out_valid), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd1);
        check("ack_out_kept", 32'(out), 32'(er));
`ifdef FP_DIV_FLAGS_EN
        check("ack_ovf_clr", 32'(ovf), 32'd0);
        check("ack_unf_clr", 32'(unf), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out", 32'(out), 32'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h30, 8'h30, 0);
        run_op(8'h48, 8'h38, 0);
        run_op(8'h30, 8'h38, 0);
        run_op(8'hB0, 8'h30, 0);
        run_op(8'h30, 8'hB0, 0);
        run_op(8'hB0, 8'hB0, 0);
        run_op(8'hC8, 8'h38, 0);
        run_op(8'h70, 8'h00, 5);
        run_op(8'h00, 8'h70, 0);
        run_op(8'hF0, 8'h00, 0);
        run_op(8'h80, 8'h7F, 0);
        run_op(8'h2F, 8'h3F, 1);

        // Reset while the mantissa iterator is busy must abort the operation
        @(negedge clk);
        a = 8'h48;
        b = 8'h38;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("midrst_aborted", 32'(out_valid), 32'd0);
        run_op(8'h30, 8'h38, 1);

        for (int n = 0; n < 40; n++)
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
